conway_sequencer: RTL and testbench

CONWAY_SEQUENCER -- requirements
Module: conway_sequencer

---
 rtl/conway_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_conway_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_sequencer.sv
// Address sequencer for a toroidal Game-of-Life engine over 9 banked BRAMs.
// Pixel (x,y) lives in bank (y mod 3)*3 + (x mod 3) at block address
// (y div 3)*WIDTH_BLOCKS + (x div 3). Each SWEEP cycle reads the full 3x3
// neighbourhood of one cell (one pixel per bank). One cycle later it writes
// that cell back.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   start, run               single-generation request / continuous mode
//   read_enable[8:0]         per-bank read strobe
//   read_addr_0..8           per-bank read block address
//   write_enable[8:0]        one-hot bank write strobe
//   write_addr               block address of the cell being written
//   frame_buffer_select      read/write frame buffer select, toggles per generation
//   busy, done               generation in progress / one-cycle completion pulse
//   generation[15:0]         completed generation count (wraps)
module conway_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 2,
  parameter int unsigned WIDTH_BLOCKS  = 2,
  parameter int unsigned HEIGHT_BLOCKS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  run,
  output logic [8:0]            read_enable,
  output logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [ADDR_WIDTH-1:0] read_addr_3,
  output logic [ADDR_WIDTH-1:0] read_addr_4,
  output logic [ADDR_WIDTH-1:0] read_addr_5,
  output logic [ADDR_WIDTH-1:0] read_addr_6,
  output logic [ADDR_WIDTH-1:0] read_addr_7,
  output logic [ADDR_WIDTH-1:0] read_addr_8,
  output logic [8:0]            write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  frame_buffer_select,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           generation
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, SWAP} state_t;

  localparam logic [ADDR_WIDTH-1:0] X_LAST        = ADDR_WIDTH'(WIDTH_BLOCKS - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST        = ADDR_WIDTH'(HEIGHT_BLOCKS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP      = ADDR_WIDTH'(WIDTH_BLOCKS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_BASE = ADDR_WIDTH'((HEIGHT_BLOCKS - 1) * WIDTH_BLOCKS);

  state_t                state, state_n;
  logic [1:0]            x_mod, x_mod_n, y_mod, y_mod_n;
  logic [ADDR_WIDTH-1:0] x_div, x_div_n, y_div, y_div_n;
  // y_base = y_div * WIDTH_BLOCKS, maintained incrementally
  logic [ADDR_WIDTH-1:0] y_base, y_base_n;

  // Neighbourhood coordinates of the next cell; index 0/1/2 = offset -1/0/+1
  logic [1:0]            nx_mod  [3];
  logic [ADDR_WIDTH-1:0] nx_div  [3];
  logic [1:0]            ny_mod  [3];
  logic [ADDR_WIDTH-1:0] ny_base [3];

  logic [ADDR_WIDTH-1:0] rd_addr   [9];
  logic [ADDR_WIDTH-1:0] rd_addr_n [9];
  logic [8:0]            rd_en_n, wr_en_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n;
  logic                  last_col, last_row;

  // Bank index without a multiplier: row offset by lookup
  function automatic logic [3:0] bank_of(input logic [1:0] ym, input logic [1:0] xm);
    logic [3:0] row;
    case (ym)
      2'd0:    row = 4'd0;
      2'd1:    row = 4'd3;
      default: row = 4'd6;
    endcase
    return row + {2'b00, xm};
  endfunction

  // Next state and raster counters
  always_comb begin
    state_n  = state;
    x_mod_n  = x_mod;
    x_div_n  = x_div;
    y_mod_n  = y_mod;
    y_div_n  = y_div;
    y_base_n = y_base;
    last_col = (x_mod == 2'd2) && (x_div == X_LAST);
    last_row = (y_mod == 2'd2) && (y_div == Y_LAST);
    case (state)
      IDLE: if (start || run) state_n = SWEEP;
      SWEEP: begin
        if (x_mod == 2'd2) begin
          x_mod_n = 2'd0;
          x_div_n = (x_div == X_LAST) ? '0 : x_div + ADDR_WIDTH'(1);
        end else begin
          x_mod_n = x_mod + 2'd1;
        end
        if (last_col) begin
          if (y_mod == 2'd2) begin
            y_mod_n = 2'd0;
            if (y_div == Y_LAST) begin
              y_div_n  = '0;
              y_base_n = '0;
            end else begin
              y_div_n  = y_div + ADDR_WIDTH'(1);
              y_base_n = y_base + ROW_STEP;
            end
          end else begin
            y_mod_n = y_mod + 2'd1;
          end
        end
        // Counters wrap to (0,0) on the last cell, ready for the next generation
        if (last_col && last_row) state_n = DRAIN;
      end
      DRAIN:   state_n = SWAP;
      SWAP:    state_n = run ? SWEEP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Toroidal neighbours of the next cell
  always_comb begin
    nx_mod[1]  = x_mod_n;
    nx_div[1]  = x_div_n;
    ny_mod[1]  = y_mod_n;
    ny_base[1] = y_base_n;
    if (x_mod_n == 2'd0) begin
      nx_mod[0] = 2'd2;
      nx_div[0] = (x_div_n == '0) ? X_LAST : x_div_n - ADDR_WIDTH'(1);
    end else begin
      nx_mod[0] = x_mod_n - 2'd1;
      nx_div[0] = x_div_n;
    end
    if (x_mod_n == 2'd2) begin
      nx_mod[2] = 2'd0;
      nx_div[2] = (x_div_n == X_LAST) ? '0 : x_div_n + ADDR_WIDTH'(1);
    end else begin
      nx_mod[2] = x_mod_n + 2'd1;
      nx_div[2] = x_div_n;
    end
    if (y_mod_n == 2'd0) begin
      ny_mod[0]  = 2'd2;
      ny_base[0] = (y_div_n == '0) ? LAST_ROW_BASE : y_base_n - ROW_STEP;
    end else begin
      ny_mod[0]  = y_mod_n - 2'd1;
      ny_base[0] = y_base_n;
    end
    if (y_mod_n == 2'd2) begin
      ny_mod[2]  = 2'd0;
      ny_base[2] = (y_div_n == Y_LAST) ? '0 : y_base_n + ROW_STEP;
    end else begin
      ny_mod[2]  = y_mod_n + 2'd1;
      ny_base[2] = y_base_n;
    end
  end

  // Next registered outputs; the 9 neighbours always land in 9 distinct banks
  always_comb begin
    for (int b = 0; b < 9; b++) rd_addr_n[b] = rd_addr[b];
    rd_en_n   = '0;
    wr_en_n   = '0;
    wr_addr_n = write_addr;
    if (state_n == SWEEP) begin
      rd_en_n = 9'h1FF;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          rd_addr_n[bank_of(ny_mod[i], nx_mod[j])] = ny_base[i] + nx_div[j];
        end
      end
    end
    // Write back the cell read this cycle, one cycle later
    if (state == SWEEP) begin
      wr_en_n   = 9'd1 << bank_of(y_mod, x_mod);
      wr_addr_n = y_base + x_div;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      x_mod               <= '0;
      x_div               <= '0;
      y_mod               <= '0;
      y_div               <= '0;
      y_base              <= '0;
      for (int b = 0; b < 9; b++) rd_addr[b] <= '0;
      read_enable         <= '0;
      write_enable        <= '0;
      write_addr          <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      frame_buffer_select <= 1'b0;
      generation          <= '0;
    end else begin
      state        <= state_n;
      x_mod        <= x_mod_n;
      x_div        <= x_div_n;
      y_mod        <= y_mod_n;
      y_div        <= y_div_n;
      y_base       <= y_base_n;
      for (int b = 0; b < 9; b++) rd_addr[b] <= rd_addr_n[b];
      read_enable  <= rd_en_n;
      write_enable <= wr_en_n;
      write_addr   <= wr_addr_n;
      busy         <= (state_n != IDLE);
      done         <= (state_n == SWAP);
      if (state == SWAP) begin
        frame_buffer_select <= ~frame_buffer_select;
        generation          <= generation + 16'd1;
      end
    end
  end

  assign read_addr_0 = rd_addr[0];
  assign read_addr_1 = rd_addr[1];
  assign read_addr_2 = rd_addr[2];
  assign read_addr_3 = rd_addr[3];
  assign read_addr_4 = rd_addr[4];
  assign read_addr_5 = rd_addr[5];
  assign read_addr_6 = rd_addr[6];
  assign read_addr_7 = rd_addr[7];
  assign read_addr_8 = rd_addr[8];

endmodule

// File: tb/tb_conway_sequencer.sv
// Self-checking bench for conway_sequencer (default 6x6 board).
// A phase-based reference model derives every expected output from pixel
// coordinates with plain div/mod arithmetic.
module tb_conway_sequencer;

  localparam int AW = 2;
  localparam int WB = 2;
  localparam int HB = 2;
  localparam int W  = 3 * WB;
  localparam int H  = 3 * HB;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset, start, run;
  logic [8:0]    read_enable, write_enable;
  logic [AW-1:0] read_addr_0, read_addr_1, read_addr_2, read_addr_3, read_addr_4;
  logic [AW-1:0] read_addr_5, read_addr_6, read_addr_7, read_addr_8, write_addr;
  logic          frame_buffer_select, busy, done;
  logic [15:0]   generation;

  conway_sequencer #(.ADDR_WIDTH(AW), .WIDTH_BLOCKS(WB), .HEIGHT_BLOCKS(HB)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run),
    .read_enable(read_enable),
    .read_addr_0(read_addr_0), .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_addr_3(read_addr_3), .read_addr_4(read_addr_4), .read_addr_5(read_addr_5),
    .read_addr_6(read_addr_6), .read_addr_7(read_addr_7), .read_addr_8(read_addr_8),
    .write_enable(write_enable), .write_addr(write_addr),
    .frame_buffer_select(frame_buffer_select), .busy(busy), .done(done),
    .generation(generation)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase -1 = idle, 0..N-1 sweep cell, N drain, N+1 swap
  int          m_phase;
  int unsigned m_gen;
  bit          m_fbs;
  int          m_ra [9];
  int          m_wa;
  logic [8:0]  m_re, m_we;
  bit          m_busy, m_done;
  int          bank_hits [9];
  int          we_pulses;

  task automatic model_outputs();
    int x, y, xx, yy, b;
    m_re = (m_phase >= 0 && m_phase < N) ? 9'h1FF : 9'h000;
    if (m_phase >= 0 && m_phase < N) begin
      x = m_phase % W;
      y = m_phase / W;
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          xx = (x + dx + W) % W;
          yy = (y + dy + H) % H;
          b  = (yy % 3) * 3 + (xx % 3);
          m_ra[b] = (yy / 3) * WB + (xx / 3);
        end
      end
    end
    if (m_phase >= 1 && m_phase <= N) begin
      x    = (m_phase - 1) % W;
      y    = (m_phase - 1) / W;
      m_we = 9'd1 << ((y % 3) * 3 + (x % 3));
      m_wa = (y / 3) * WB + (x / 3);
    end else begin
      m_we = 9'h000;
    end
    m_busy = (m_phase >= 0);
    m_done = (m_phase == N + 1);
  endtask

  task automatic model_reset();
    m_phase = -1;
    m_gen   = 0;
    m_fbs   = 1'b0;
    for (int b = 0; b < 9; b++) m_ra[b] = 0;
    m_wa = 0;
    model_outputs();
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (m_phase < 0) begin
        if (start || run) m_phase = 0;
      end else if (m_phase < N + 1) begin
        m_phase++;
      end else begin
        m_gen   = (m_gen + 1) & 32'hFFFF;
        m_fbs   = ~m_fbs;
        m_phase = run ? 0 : -1;
      end
      model_outputs();
    end
  endtask

  task automatic compare_all();
    logic [31:0] ra_obs, ra_exp;
    ra_obs = 32'({read_addr_8, read_addr_7, read_addr_6, read_addr_5, read_addr_4,
                  read_addr_3, read_addr_2, read_addr_1, read_addr_0});
    ra_exp = '0;
    for (int b = 0; b < 9; b++) ra_exp = ra_exp | (32'(m_ra[b]) << (b * AW));
    check("read_enable", 32'(read_enable), 32'(m_re));
    check("read_addr", ra_obs, ra_exp);
    check("write_enable", 32'(write_enable), 32'(m_we));
    check("write_addr", 32'(write_addr), 32'(m_wa));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("fb_select", 32'(frame_buffer_select), 32'(m_fbs));
    check("generation", 32'(generation), m_gen);
  endtask

  // One clock: model follows the edge, outputs sampled at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (write_enable != 9'h000) we_pulses++;
    for (int b = 0; b < 9; b++) if (write_enable[b]) bank_hits[b]++;
  endtask

  // Assert reset mid-cycle, check immediately, hold one edge, release
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_write_enable", 32'(write_enable), 32'h0);
    step();
    reset = 1'b0;
  endtask

  int done_at, prev_done, done_count;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    run   = 1'b0;
    for (int b = 0; b < 9; b++) bank_hits[b] = 0;
    we_pulses = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    step();
    reset = 1'b0;

    // Single generation with directed address spot checks
    for (int b = 0; b < 9; b++) bank_hits[b] = 0;
    we_pulses = 0;
    done_at   = -1;
    start     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      start = 1'b0;
      if (done) done_at = i;
      if (i == 0) begin
        check("c00_ra0", 32'(read_addr_0), 32'd0);
        check("c00_ra1", 32'(read_addr_1), 32'd0);
        check("c00_ra8", 32'(read_addr_8), 32'd3);
        check("c00_ra2", 32'(read_addr_2), 32'd1);
        check("c00_re", 32'(read_enable), 32'h1FF);
      end
      if (i == 1) begin
        check("c00_we", 32'(write_enable), 32'h001);
        check("c00_wa", 32'(write_addr), 32'd0);
      end
      if (i == 4) begin
        check("c30_we", 32'(write_enable), 32'h001);
        check("c30_wa", 32'(write_addr), 32'd1);
      end
      if (i == 35) check("c55_ra0", 32'(read_addr_0), 32'd0);
      if (i == 36) begin
        check("c55_we", 32'(write_enable), 32'h100);
        check("c55_wa", 32'(write_addr), 32'd3);
      end
      if (i == 38) check("idle_busy", 32'(busy), 32'd0);
    end
    check("done_cycle", 32'(done_at), 32'd37);
    check("gen_after_one", 32'(generation), 32'd1);
    check("fbs_after_one", 32'(frame_buffer_select), 32'd1);
    check("we_pulses", 32'(we_pulses), 32'd36);
    for (int b = 0; b < 9; b++) check("bank_hits", 32'(bank_hits[b]), 32'd4);

    // Continuous mode for three generations, with ignored start pulses
    pulse_reset();
    run        = 1'b1;
    prev_done  = -1;
    done_count = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      start = (i < 100) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      if (i == 86) run = 1'b0;
      if (done) begin
        if (prev_done >= 0) check("done_period", 32'(i - prev_done), 32'd38);
        prev_done = i;
        done_count++;
      end
    end
    start = 1'b0;
    check("run_done_count", 32'(done_count), 32'd3);
    check("run_gen", 32'(generation), 32'd3);
    check("run_fbs", 32'(frame_buffer_select), 32'd1);

    // Reset in sweep cycle 20, then stay idle without start
    pulse_reset();
    start = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      step();
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_idle", 32'(busy), 32'd0);
    end

    // Generation counter wrap
    force dut.generation = 16'hFFFF;
    #1;
    release dut.generation;
    m_gen = 32'hFFFF;
    check("gen_forced", 32'(generation), 32'hFFFF);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      start = 1'b0;
    end
    check("gen_wrap", 32'(generation), 32'h0000);
    check("gen_wrap_fbs", 32'(frame_buffer_select), 32'd1);

    // Randomized start/run/reset traffic
    for (int i = 0; i < 900; i++) begin
      start = 1'($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
